cdr_link_supervisor: RTL and testbench

//  Sequences the 4x-oversampling CDR on the 200MHz link clock: holds CDR in reset, releases it, and waits for lock.

---
 rtl/cdr_link_pkg.sv | 27 ++
 rtl/sup_sat_counter.sv | 26 ++
 rtl/cdr_link_supervisor.sv | 150 +++++++++++++++
 tb/tb_cdr_link_supervisor.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_link_pkg.sv
// Shared types and constants for the CDR link supervisor: state encoding,
// statistics counter width and the backoff length helper.
package cdr_link_pkg;

  localparam int STATE_W           = 3;
  localparam int STAT_W            = 16;
  localparam int BACKOFF_SHIFT_CAP = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RST       = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_UP        = 3'd4,
    ST_BACKOFF   = 3'd5,
    ST_FAULT     = 3'd6
  } sup_state_t;

  // Backoff doubles per consecutive failure; the first failure (retry=1) gets base.
  function automatic int backoff_len(input int base, input logic [3:0] retry);
    int sh;
    sh = (retry == 4'd0) ? 0 : int'(retry) - 1;
    if (sh > BACKOFF_SHIFT_CAP) sh = BACKOFF_SHIFT_CAP;
    return base << sh;
  endfunction

endpackage

// File: rtl/sup_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sup_sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cdr_link_supervisor.sv
// CDR bring-up supervisor: reset, lock wait, settle qualification, bit_valid
// watchdog and doubling-backoff retrain. Define CDR_SUP_STATS_EN for the stat counters.
module cdr_link_supervisor
  import cdr_link_pkg::*;
#(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int SETTLE       = 128,
  parameter int VALID_GAP    = 64,
  parameter int BACKOFF_BASE = 256,
  parameter int MAX_RETRY    = 7
) (
  input  logic               clk_link,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear_stats,
  input  logic               cdr_locked,
  input  logic               cdr_bit_valid,
  output logic               cdr_rst_n,
  output logic               link_up,
  output logic               fault,
  output logic [STATE_W-1:0] sup_state,
  output logic [3:0]         retry_cnt,
  output logic [STAT_W-1:0]  loss_cnt,
  output logic [STAT_W-1:0]  attempt_cnt
);

  localparam int TMR_BO_MAX = BACKOFF_BASE << BACKOFF_SHIFT_CAP;
  localparam int TMR_MAX    = (LOCK_TIMEOUT > TMR_BO_MAX) ? LOCK_TIMEOUT : TMR_BO_MAX;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  sup_state_t       r_state, w_next_state;
  logic [TMR_W-1:0] r_timer, w_timer_next;
  logic [3:0]       r_retry, w_retry_next, w_retry_inc;
  logic             w_timer_zero, w_fail, w_loss, w_attempt;
  logic             r_cdr_rst_n, r_link_up, r_fault;

  always_comb begin
    w_timer_zero = (r_timer == '0);
    w_retry_inc  = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
    w_next_state = r_state;
    w_retry_next = r_retry;
    w_fail       = 1'b0;
    w_loss       = 1'b0;
    if (!enable) begin
      w_next_state = ST_IDLE;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_retry_next = '0;
          w_next_state = ST_RST;
        end
        ST_RST:       if (w_timer_zero) w_next_state = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (cdr_locked)        w_next_state = ST_SETTLE;
          else if (w_timer_zero) w_fail = 1'b1;
        end
        ST_SETTLE: begin
          // A drop on the final settle cycle still counts as a failure.
          if (!cdr_locked) begin
            w_fail = 1'b1;
          end else if (w_timer_zero) begin
            w_next_state = ST_UP;
            w_retry_next = '0;
          end
        end
        ST_UP: begin
          if (!cdr_locked || (w_timer_zero && !cdr_bit_valid)) begin
            w_loss       = 1'b1;
            w_next_state = ST_RST;
          end
        end
        ST_BACKOFF:   if (w_timer_zero) w_next_state = ST_RST;
        ST_FAULT:     w_next_state = ST_FAULT;
        default:      w_next_state = ST_IDLE;
      endcase
      if (w_fail) begin
        w_retry_next = w_retry_inc;
        w_next_state = (w_retry_inc >= MAX_RETRY_L) ? ST_FAULT : ST_BACKOFF;
      end
    end

    // Shared timer: reloaded on entry, bit_valid rearms the UP watchdog, never wraps.
    w_timer_next = w_timer_zero ? r_timer : r_timer - TMR_W'(1);
    if (w_next_state != r_state) begin
      case (w_next_state)
        ST_RST:       w_timer_next = TMR_W'(RST_HOLD - 1);
        ST_WAIT_LOCK: w_timer_next = TMR_W'(LOCK_TIMEOUT - 1);
        ST_SETTLE:    w_timer_next = TMR_W'(SETTLE - 1);
        ST_UP:        w_timer_next = TMR_W'(VALID_GAP - 1);
        ST_BACKOFF:   w_timer_next = TMR_W'(backoff_len(BACKOFF_BASE, w_retry_next) - 1);
        default:      w_timer_next = '0;
      endcase
    end else if ((r_state == ST_UP) && cdr_bit_valid) begin
      w_timer_next = TMR_W'(VALID_GAP - 1);
    end

    w_attempt = (w_next_state == ST_RST) && (r_state != ST_RST);
  end

  always_ff @(posedge clk_link or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_retry     <= '0;
      r_cdr_rst_n <= 1'b0;
      r_link_up   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_timer     <= w_timer_next;
      r_retry     <= w_retry_next;
      r_cdr_rst_n <= (w_next_state inside {ST_WAIT_LOCK, ST_SETTLE, ST_UP});
      r_link_up   <= (w_next_state == ST_UP);
      r_fault     <= (w_next_state == ST_FAULT);
    end
  end

  assign cdr_rst_n = r_cdr_rst_n;
  assign link_up   = r_link_up;
  assign fault     = r_fault;
  assign sup_state = r_state;
  assign retry_cnt = r_retry;

`ifdef CDR_SUP_STATS_EN
  sup_sat_counter #(.W(STAT_W)) u_loss_cnt (
    .i_clk   (clk_link),
    .i_rst_n (rst_n),
    .i_inc   (w_loss),
    .i_clr   (clear_stats),
    .o_count (loss_cnt)
  );

  sup_sat_counter #(.W(STAT_W)) u_attempt_cnt (
    .i_clk   (clk_link),
    .i_rst_n (rst_n),
    .i_inc   (w_attempt),
    .i_clr   (clear_stats),
    .o_count (attempt_cnt)
  );
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{clear_stats, w_loss, w_attempt};
  assign loss_cnt       = '0;
  assign attempt_cnt    = '0;
`endif

endmodule

// File: tb/tb_cdr_link_supervisor.sv
// Bench for cdr_link_supervisor: directed bring-up/retrain scenarios plus a
// random phase, all checked every cycle against a cycle-count reference model.
`timescale 1ns/100ps
module tb_cdr_link_supervisor;

  localparam int RST_HOLD     = 16;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int SETTLE_LEN   = 128;
  localparam int VALID_GAP    = 64;
  localparam int BACKOFF_BASE = 256;
  localparam int MAX_RETRY    = 7;

  localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_SETTLE = 3;
  localparam int P_UP = 4, P_BACKOFF = 5, P_FAULT = 6;

`ifdef CDR_SUP_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk_link = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_stats = 1'b0;
  logic        cdr_locked = 1'b0;
  logic        cdr_bit_valid = 1'b0;
  logic        cdr_rst_n, link_up, fault;
  logic [2:0]  sup_state;
  logic [3:0]  retry_cnt;
  logic [15:0] loss_cnt, attempt_cnt;

  always #2.5 clk_link = ~clk_link;

  cdr_link_supervisor dut (
    .clk_link      (clk_link),
    .rst_n         (rst_n),
    .enable        (enable),
    .clear_stats   (clear_stats),
    .cdr_locked    (cdr_locked),
    .cdr_bit_valid (cdr_bit_valid),
    .cdr_rst_n     (cdr_rst_n),
    .link_up       (link_up),
    .fault         (fault),
    .sup_state     (sup_state),
    .retry_cnt     (retry_cnt),
    .loss_cnt      (loss_cnt),
    .attempt_cnt   (attempt_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts cycles spent in each phase upward and compares against the
  // phase lengths; expected outputs per cycle go into exp_q.
  int m_ph, m_el, m_gap, m_retry, m_loss, m_att;
  int g_cyc = 0;
  logic [41:0] exp_q[$];

  function automatic int backoff_cycles(input int retry);
    int sh;
    sh = retry - 1;
    if (sh > 8) sh = 8;
    return BACKOFF_BASE * (1 << sh);
  endfunction

  function automatic int fail_next();
    m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    return (m_retry >= MAX_RETRY) ? P_FAULT : P_BACKOFF;
  endfunction

  function automatic logic [41:0] model_outputs();
    logic [15:0] l, a;
    logic        rn, up, fl;
    l  = STATS_EN ? 16'(m_loss) : 16'd0;
    a  = STATS_EN ? 16'(m_att) : 16'd0;
    rn = (m_ph == P_WAIT) || (m_ph == P_SETTLE) || (m_ph == P_UP);
    up = (m_ph == P_UP);
    fl = (m_ph == P_FAULT);
    return {3'(m_ph), rn, up, fl, 4'(m_retry), l, a};
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_el = 0; m_gap = 0; m_retry = 0; m_loss = 0; m_att = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic en, input logic lk, input logic bv, input logic clr);
    int nph;
    bit loss_ev, att_ev;
    nph = m_ph;
    loss_ev = 0;
    if (!en) begin
      nph = P_IDLE;
    end else begin
      case (m_ph)
        P_IDLE:    nph = P_RST;
        P_RST:     if (m_el + 1 == RST_HOLD) nph = P_WAIT;
        P_WAIT:    if (lk) nph = P_SETTLE; else if (m_el + 1 == LOCK_TIMEOUT) nph = fail_next();
        P_SETTLE: begin
          if (!lk) nph = fail_next();
          else if (m_el + 1 == SETTLE_LEN) begin nph = P_UP; m_retry = 0; end
        end
        P_UP: begin
          if (!lk || (!bv && (m_gap + 1 == VALID_GAP))) begin nph = P_RST; loss_ev = 1; end
          else m_gap = bv ? 0 : m_gap + 1;
        end
        P_BACKOFF: if (m_el + 1 == backoff_cycles(m_retry)) nph = P_RST;
        default:   nph = m_ph;
      endcase
    end
    if (nph == P_IDLE) m_retry = 0;
    att_ev = (nph == P_RST) && (m_ph != P_RST);
    if (nph != m_ph) begin m_el = 0; m_gap = 0; end
    else m_el++;
    if (clr) begin
      m_loss = 0; m_att = 0;
    end else begin
      if (loss_ev && m_loss < 65535) m_loss++;
      if (att_ev && m_att < 65535) m_att++;
    end
    m_ph = nph;
    exp_q.push_back(model_outputs());
  endtask

  task automatic compare_outputs();
    logic [41:0] e;
    e = exp_q.pop_front();
    check("sup_state", sup_state, e[41:39]);
    check("flags", {cdr_rst_n, link_up, fault}, e[38:36]);
    check("retry_cnt", retry_cnt, e[35:32]);
    check("loss_cnt", loss_cnt, e[31:16]);
    check("attempt_cnt", attempt_cnt, e[15:0]);
  endtask

  // ---------------- driver ----------------
  function automatic logic bv_nom();
    return (g_cyc % 4) == 0;
  endfunction

  task automatic tick(input logic en, input logic lk, input logic bv, input logic clr);
    @(negedge clk_link);
    enable = en; cdr_locked = lk; cdr_bit_valid = bv; clear_stats = clr;
    @(posedge clk_link);
    g_cyc++;
    model_step(en, lk, bv, clr);
    #1 compare_outputs();
  endtask

  task automatic bring_up();
    for (int i = 0; i < 2000 && !link_up; i++) tick(1'b1, 1'b1, bv_nom(), 1'b0);
    check("bring_up_link_up", link_up, 1);
  endtask

  // ---------------- stimulus ----------------
  int  cnt, lag, lock_tick, n_bo, cur_bo, stall;
  bit  seen_up, lk_r, en_r;
  logic lk;

  initial begin
    model_reset();
    @(negedge clk_link);
    #1;
    check("rst_cdr_rst_n", cdr_rst_n, 0);
    check("rst_link_up", link_up, 0);
    check("rst_fault", fault, 0);
    check("rst_state", sup_state, P_IDLE);
    check("rst_retry", retry_cnt, 0);
    check("rst_loss", loss_cnt, 0);
    check("rst_attempt", attempt_cnt, 0);
    @(posedge clk_link);
    #1 rst_n = 1'b1;

    // T1: lock 50 cycles after CDR release, nominal bit_valid cadence
    cnt = 0; lag = -1; lock_tick = -1;
    for (int i = 0; i < 2000 && lag < 0; i++) begin
      lk = ((m_ph == P_WAIT) && (m_el >= 50)) || (m_ph == P_SETTLE) || (m_ph == P_UP);
      if (lk && lock_tick < 0) lock_tick = i;
      tick(1'b1, lk, bv_nom(), 1'b0);
      if (!cdr_rst_n) cnt++;
      if (link_up) lag = i - lock_tick;
    end
    check("t1_cdr_rst_low_cycles", cnt, RST_HOLD);
    check("t1_lock_to_link_up", lag, SETTLE_LEN);
    check("t1_attempt", attempt_cnt, STATS_EN ? 1 : 0);
    repeat (100) tick(1'b1, 1'b1, bv_nom(), 1'b0);

    // T3: one-cycle lock drop in UP
    tick(1'b1, 1'b0, bv_nom(), 1'b0);
    check("t3_link_up", link_up, 0);
    check("t3_state", sup_state, P_RST);
    check("t3_retry", retry_cnt, 0);
    check("t3_loss", loss_cnt, STATS_EN ? 1 : 0);
    bring_up();
    repeat (20) tick(1'b1, 1'b1, bv_nom(), 1'b0);

    // T4: bit_valid stall with lock held
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 200 && link_up; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
    check("t4_gap_cycles", cnt, VALID_GAP);
    check("t4_loss", loss_cnt, STATS_EN ? 2 : 0);
    bring_up();
    repeat (10) tick(1'b1, 1'b1, bv_nom(), 1'b0);

    // T5: lock drops at settle cycle 100
    tick(1'b1, 1'b0, bv_nom(), 1'b0);
    for (int i = 0; i < 500 && !((m_ph == P_SETTLE) && (m_el == 99)); i++)
      tick(1'b1, 1'b1, bv_nom(), 1'b0);
    seen_up = 0;
    tick(1'b1, 1'b0, bv_nom(), 1'b0);
    check("t5_retry", retry_cnt, 1);
    check("t5_state", sup_state, P_BACKOFF);
    cnt = 0;
    for (int i = 0; i < 1000 && sup_state == 3'd5; i++) begin
      cnt++;
      tick(1'b1, 1'b0, bv_nom(), 1'b0);
      if (link_up) seen_up = 1;
    end
    check("t5_backoff_cycles", cnt, BACKOFF_BASE);
    check("t5_no_link_up", seen_up, 0);
    bring_up();
    repeat (10) tick(1'b1, 1'b1, bv_nom(), 1'b0);

    // T6: clear_stats on the same cycle as a loss
    tick(1'b1, 1'b0, bv_nom(), 1'b1);
    check("t6_clr_loss", loss_cnt, 0);
    check("t6_clr_attempt", attempt_cnt, 0);
    check("t6_state", sup_state, P_RST);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    // T2: lock never arrives; backoff doubles until FAULT
    n_bo = 0; cur_bo = 0;
    for (int i = 0; i < 60000 && !fault; i++) begin
      tick(1'b1, 1'b0, bv_nom(), 1'b0);
      if (sup_state == 3'd5) cur_bo++;
      else if (cur_bo > 0) begin
        check($sformatf("t2_backoff_%0d", n_bo), cur_bo, BACKOFF_BASE << n_bo);
        n_bo++;
        cur_bo = 0;
      end
    end
    check("t2_fault", fault, 1);
    check("t2_retry", retry_cnt, MAX_RETRY);
    check("t2_attempt", attempt_cnt, STATS_EN ? 7 : 0);
    check("t2_backoff_count", n_bo, MAX_RETRY - 1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_disable_state", sup_state, P_IDLE);
    check("t2_disable_fault", fault, 0);

    // T6: async reset in BACKOFF
    for (int i = 0; i < 6000 && sup_state != 3'd5; i++) tick(1'b1, 1'b0, bv_nom(), 1'b0);
    check("t6_reached_backoff", sup_state, P_BACKOFF);
    repeat (5) tick(1'b1, 1'b0, bv_nom(), 1'b0);
    @(negedge clk_link);
    #0.5 rst_n = 1'b0;
    #1;
    check("arst_cdr_rst_n", cdr_rst_n, 0);
    check("arst_link_up", link_up, 0);
    check("arst_fault", fault, 0);
    check("arst_state", sup_state, P_IDLE);
    check("arst_retry", retry_cnt, 0);
    check("arst_loss", loss_cnt, 0);
    check("arst_attempt", attempt_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk_link);
    #1 rst_n = 1'b1;

    // Random phase: slow lock toggling, bit_valid stalls, rare disable/clear
    lk_r = 1; en_r = 1; stall = 0;
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 299) == 0) lk_r = !lk_r;
      if (en_r && $urandom_range(0, 1999) == 0) en_r = 0;
      else if (!en_r && $urandom_range(0, 19) == 0) en_r = 1;
      if (stall == 0 && $urandom_range(0, 499) == 0) stall = $urandom_range(1, 100);
      if (stall > 0) stall--;
      tick(en_r, lk_r,
           (stall > 0) ? 1'b0 : (bv_nom() || ($urandom_range(0, 15) == 0)),
           $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
